// File: rtl/score_display_ctrl_pkg.sv
// Shared definitions for the score display controller: FSM states, segment
// constants and the double-dabble nibble adjust helper.
package score_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int          NIBBLE_W  = 4;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [NIBBLE_W-1:0] add3(input logic [NIBBLE_W-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Hex digit to active-low seven-segment decoder, segment order gfedcba.
module seven_segment_display (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score readout controller: binary value -> BCD by serial double-dabble, committed
// to a digit register that drives NUM_DIGITS seven-segment displays with blanking and blink.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int VALUE_W    = 20,
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    value_valid,
  output logic                    ready,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int          BCD_W   = NIBBLE_W * NUM_DIGITS;
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
  localparam int          CNT_W   = $clog2(VALUE_W + 1);
  localparam int          BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic logic is_over(input logic [VALUE_W-1:0] v);
    return 64'(v) > MAX_VAL;
  endfunction

  // Out-of-range inputs convert as all nines so the BCD accumulator never loses bits.
  function automatic logic [VALUE_W-1:0] sat_value(input logic [VALUE_W-1:0] v);
    return is_over(v) ? MAX_VAL[VALUE_W-1:0] : v;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < NUM_DIGITS; k++)
      r[k*NIBBLE_W +: NIBBLE_W] = add3(b[k*NIBBLE_W +: NIBBLE_W]);
    return r;
  endfunction

  state_t             state, state_nxt;
  logic               accept, shift_en, commit;
  logic [CNT_W-1:0]   bit_cnt;
  logic               over_flag;
  logic [VALUE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   digit_reg;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;
  logic               blink_off;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic               upper_zero;
  logic [6:0]         seg_raw [NUM_DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (value_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == CNT_W'(1)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      over_flag <= 1'b0;
      digit_reg <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        bit_cnt   <= CNT_W'(VALUE_W);
        over_flag <= is_over(value);
      end else if (shift_en) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
      end
      if (commit) begin
        digit_reg <= bcd_acc;
        overflow  <= over_flag;
      end
    end
  end

  // Conversion datapath: {bcd, bin} shifts left once per SHIFT cycle, MSB beyond bcd dropped.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_sr  <= sat_value(value);
      bcd_acc <= '0;
    end else if (shift_en) begin
      {bcd_acc, bin_sr} <= {dabble_adjust(bcd_acc), bin_sr} << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Gating by blink_en here makes the display reappear in the same cycle blink is dropped.
  assign blink_off = blink_en & ~phase_on;

  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero  = upper_zero & (digit_reg[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_blank[k] = blank_lz & upper_zero;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seven_segment_display u_dec (
      .digit (digit_reg[k*NIBBLE_W +: NIBBLE_W]),
      .seg   (seg_raw[k])
    );
    assign hex_out[7*k +: 7] = (blink_off | lz_blank[k]) ? SEG_BLANK : seg_raw[k];
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed vector table, random loads
// against a decimal reference model, and hand-written busy/blink/reset sequences.
module tb_score_display_ctrl;

  localparam int VALUE_W = 20;
  localparam int ND      = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [VALUE_W-1:0] value = '0;
  logic              value_valid = 1'b0;
  logic              ready;
  logic              blank_lz = 1'b1;
  logic              blink_en = 1'b0;
  logic              overflow;
  logic [7*ND-1:0]   hex_out;

  int n_checks = 0;
  int n_pass   = 0;

  score_display_ctrl #(.VALUE_W(VALUE_W), .NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .ready(ready),
    .blank_lz(blank_lz), .blink_en(blink_en), .overflow(overflow), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VALUE_W-1:0] val;
    logic               bl;
    logic [7*ND-1:0]    hex;
    logic               ovf;
  } vec_t;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] lut [10];
    lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return lut[d];
  endfunction

  // Reference: decimal digits of the clamped value, blank zero digits above the highest nonzero.
  function automatic logic [7*ND-1:0] exp_display(input int unsigned v, input logic bl);
    int unsigned x;
    int          d [ND];
    int          top;
    logic [7*ND-1:0] r;
    x   = (v > 999999) ? 999999 : v;
    top = 0;
    for (int k = 0; k < ND; k++) begin
      d[k] = x % 10;
      x    = x / 10;
      if (d[k] != 0) top = k;
    end
    for (int k = 0; k < ND; k++)
      r[7*k +: 7] = (bl && k > top) ? 7'b1111111 : seg_of(d[k]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      tick;
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic do_load(input logic [VALUE_W-1:0] v, output int busy);
    wait_ready;
    value       = v;
    value_valid = 1'b1;
    tick;
    value_valid = 1'b0;
    busy = 0;
    while (!ready && busy < 100) begin
      busy++;
      tick;
    end
  endtask

  vec_t vecs [8];
  int   busy;
  int   lows;
  int unsigned rv;
  logic rbl;

  initial begin
    vecs[0] = '{20'd123456,  1'b0, {S1, S2, S3, S4, S5, S6}, 1'b0};
    vecs[1] = '{20'd1048575, 1'b0, {S9, S9, S9, S9, S9, S9}, 1'b1};
    vecs[2] = '{20'd5,       1'b1, {SB, SB, SB, SB, SB, S5}, 1'b0};
    vecs[3] = '{20'd0,       1'b1, {SB, SB, SB, SB, SB, S0}, 1'b0};
    vecs[4] = '{20'd100000,  1'b1, {S1, S0, S0, S0, S0, S0}, 1'b0};
    vecs[5] = '{20'd1000000, 1'b0, {S9, S9, S9, S9, S9, S9}, 1'b1};
    vecs[6] = '{20'd999999,  1'b0, {S9, S9, S9, S9, S9, S9}, 1'b0};
    vecs[7] = '{20'd7040,    1'b1, {SB, SB, S7, S0, S4, S0}, 1'b0};

    // Reset state
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_hex_lz", 64'(hex_out), 64'({SB, SB, SB, SB, SB, S0}));
    tick;
    rst = 1'b0;
    blank_lz = 1'b0;
    #1;
    check("rst_hex_nolz", 64'(hex_out), 64'({S0, S0, S0, S0, S0, S0}));

    // Directed table
    foreach (vecs[i]) begin
      blank_lz = vecs[i].bl;
      do_load(vecs[i].val, busy);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd21);
      check($sformatf("vec%0d_hex", i), 64'(hex_out), 64'(vecs[i].hex));
      check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
    end

    // Random loads against the model
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom_range(0, 99);
        1:       rv = $urandom_range(0, 999999);
        2:       rv = $urandom_range(1000000, 1048575);
        default: rv = $urandom_range(0, 1048575);
      endcase
      rbl = 1'($urandom_range(0, 1));
      blank_lz = rbl;
      do_load(VALUE_W'(rv), busy);
      check($sformatf("rnd%0d_busy", i), 64'(busy), 64'd21);
      check($sformatf("rnd%0d_hex v=%0d", i, rv), 64'(hex_out), 64'(exp_display(rv, rbl)));
      check($sformatf("rnd%0d_ovf", i), 64'(overflow), 64'(rv > 999999));
    end

    // Valid held while busy; value changes before ready returns
    blank_lz = 1'b0;
    wait_ready;
    value = 20'd500;
    value_valid = 1'b1;
    tick;
    value = 20'd42;
    repeat (10) tick;
    value = 20'd77;
    wait_ready;
    tick;
    value_valid = 1'b0;
    check("hold_busy_after_accept", 64'(ready), 64'd0);
    wait_ready;
    check("hold_hex_77", 64'(hex_out), 64'(exp_display(77, 1'b0)));
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (!ready) lows++;
      tick;
    end
    check("hold_single_conversion", 64'(lows), 64'd0);

    // Blink: phase toggles every 4 cycles
    blink_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      check($sformatf("blink_t%0d", i), 64'(hex_out),
            (((i / 4) % 2) == 1) ? {64{1'b1}} >> (64 - 7*ND) : 64'(exp_display(77, 1'b0)));
    end
    blink_en = 1'b0;
    #1;
    check("blink_drop_same_cycle", 64'(hex_out), 64'(exp_display(77, 1'b0)));
    tick;
    check("blink_drop_next", 64'(hex_out), 64'(exp_display(77, 1'b0)));

    // Reset mid-conversion
    blank_lz = 1'b0;
    wait_ready;
    value = 20'd999;
    value_valid = 1'b1;
    tick;
    value_valid = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_hex", 64'(hex_out), 64'(exp_display(0, 1'b0)));
    check("midrst_ovf", 64'(overflow), 64'd0);
    tick;
    rst = 1'b0;
    repeat (25) tick;
    check("midrst_no_late_commit", 64'(hex_out), 64'(exp_display(0, 1'b0)));
    do_load(20'd999, busy);
    check("midrst_reload_busy", 64'(busy), 64'd21);
    check("midrst_reload_hex", 64'(hex_out), 64'(exp_display(999, 1'b0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
